// File: rtl/nvram_ioctl_responder.sv
// nvram_ioctl_responder
//
// Bridges the data_io ioctl download/upload protocol to a single-port NVRAM
// with a one-cycle read latency. A selected download streams bytes into the
// NVRAM. A selected upload fetches one byte per ioctl_addr change and
// presents it on ioctl_din two cycles later. Addresses beyond the image read
// as 8'hFF and are never written.
//
// Optional feature macro: NVRAM_DIRTY_TRACK_EN
//   defined   -> dirty tracks core-side writes since the last full save/load
//   undefined -> dirty is tied low and core_wr is ignored
module nvram_ioctl_responder #(
  parameter logic [7:0] INDEX = 8'hFF,
  parameter int         AW    = 9
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic [24:0]   ioctl_addr,
  input  logic          ioctl_wr,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  output logic [AW-1:0] nvram_a,
  output logic [7:0]    nvram_d,
  output logic          nvram_we,
  input  logic [7:0]    nvram_q,
  input  logic          core_wr,
  output logic          busy,
  output logic          dirty
);

  typedef enum logic [2:0] {
    IDLE,
    DL,
    UL_ISSUE,
    UL_WAIT,
    UL_HOLD
  } state_t;

  localparam logic [24:0] TOP_ADDR = 25'((64'd1 << AW) - 64'd1);

  state_t      state;
  logic        wr_q;       // previous ioctl_wr, for rise detection
  logic        ul_q;       // previous ioctl_upload, for rise detection
  logic [24:0] addr_q;     // full address of the fetch in flight / last fetched
  logic        fetch_oor;  // fetch in flight targets an address outside the image
  logic        armed;      // both session requests seen low since reset

  logic sel;
  logic addr_oor;
  logic addr_chg;
  logic wr_rise;
  logic dl_start;
  logic ul_start;
  logic in_upload;
  logic issue;

  assign sel       = (ioctl_index == INDEX);
  // Range check uses every address bit; only nvram_a itself is masked.
  assign addr_oor  = ((ioctl_addr >> AW) != 25'd0);
  assign addr_chg  = (ioctl_addr != addr_q);
  assign wr_rise   = ioctl_wr & ~wr_q;
  // armed blocks a request that was already high when reset released.
  assign dl_start  = armed & sel & ioctl_download;
  assign ul_start  = armed & sel & ioctl_upload & ~ul_q & ~dl_start;
  assign in_upload = (state == UL_ISSUE) || (state == UL_WAIT) || (state == UL_HOLD);
  // A fetch is (re)started on session entry or on any address change while
  // the upload is still active, including mid-fetch (which drops the old one).
  assign issue     = ((state == IDLE) && ul_start) ||
                     (in_upload && ioctl_upload && addr_chg);

`ifdef NVRAM_DIRTY_TRACK_EN
  logic reached_top;  // current upload has visited the last image byte
  logic end_clear;

  assign end_clear = ((state == DL) && !ioctl_download) ||
                     (in_upload && !ioctl_upload && reached_top);
`else
  logic unused_core_wr;

  assign unused_core_wr = core_wr;
  assign dirty          = 1'b0;
`endif

  // Session FSM, NVRAM port drive, upload byte capture and dirty tracking.
  // NOTE: every register here uses <= so all reads see the pre-edge values;
  // blocking assignments would make results depend on statement order.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ioctl_din <= 8'h00;
      nvram_a   <= '0;
      nvram_d   <= 8'h00;
      nvram_we  <= 1'b0;
      busy      <= 1'b0;
      wr_q      <= 1'b0;
      ul_q      <= 1'b0;
      addr_q    <= 25'd0;
      fetch_oor <= 1'b0;
      armed     <= 1'b0;
`ifdef NVRAM_DIRTY_TRACK_EN
      reached_top <= 1'b0;
      dirty       <= 1'b0;
`endif
    end else begin
      wr_q     <= ioctl_wr;
      ul_q     <= ioctl_upload;
      nvram_we <= 1'b0;
      if (!ioctl_download && !ioctl_upload) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (dl_start)      state <= DL;
          else if (ul_start) state <= UL_ISSUE;
        end

        DL: begin
          if (!ioctl_download) begin
            state <= IDLE;
          end else if (wr_rise && !addr_oor) begin
            nvram_we <= 1'b1;
            nvram_a  <= ioctl_addr[AW-1:0];
            nvram_d  <= ioctl_dout;
          end
        end

        UL_ISSUE: begin
          if (!ioctl_upload) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!addr_chg) begin
            state <= UL_WAIT;
          end
        end

        UL_WAIT: begin
          if (!ioctl_upload) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (addr_chg) begin
            state <= UL_ISSUE;
          end else begin
            // nvram_q now reflects the address driven two edges ago.
            ioctl_din <= fetch_oor ? 8'hFF : nvram_q;
            busy      <= 1'b0;
            state     <= UL_HOLD;
          end
        end

        UL_HOLD: begin
          if (!ioctl_upload)  state <= IDLE;
          else if (addr_chg)  state <= UL_ISSUE;
        end

        default: state <= IDLE;
      endcase

      if (issue) begin
        addr_q    <= ioctl_addr;
        fetch_oor <= addr_oor;
        busy      <= 1'b1;
        // Out-of-range fetches leave the NVRAM address untouched: no read.
        if (!addr_oor) nvram_a <= ioctl_addr[AW-1:0];
      end

`ifdef NVRAM_DIRTY_TRACK_EN
      if (ul_start)
        reached_top <= 1'b0;
      else if (in_upload && ioctl_upload && (ioctl_addr == TOP_ADDR))
        reached_top <= 1'b1;

      // A core write in the clearing cycle must not be lost.
      if (core_wr)        dirty <= 1'b1;
      else if (end_clear) dirty <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_nvram_ioctl_responder.sv
// Testbench for nvram_ioctl_responder (default parameters, 512-byte image).
// Stimulus pushes expected NVRAM writes and upload bytes into queues; a
// monitor on the falling clock edge pops and compares them whenever the DUT
// pulses nvram_we or drops busy after a fetch.
module tb_nvram_ioctl_responder;

  localparam int NV = 512;
`ifdef NVRAM_DIRTY_TRACK_EN
  localparam logic DT = 1'b1;
`else
  localparam logic DT = 1'b0;
`endif

  typedef struct {
    logic [8:0] a;
    logic [7:0] d;
    int         cyc;
  } wr_exp_t;

  typedef struct {
    logic [7:0] d;
    int         busy_len;
    int         cyc;
  } rd_exp_t;

  logic        clk_sys;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_din;
  logic [8:0]  nvram_a;
  logic [7:0]  nvram_d;
  logic        nvram_we;
  logic [7:0]  nvram_q;
  logic        core_wr;
  logic        busy;
  logic        dirty;

  logic [7:0] mem     [NV];
  logic [7:0] ref_mem [NV];
  wr_exp_t    wq[$];
  rd_exp_t    rq[$];
  int         checks;
  int         errors;
  int         cyc;
  int         busy_cnt;
  logic       busy_prev;

  nvram_ioctl_responder #(.INDEX(8'hFF), .AW(9)) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_upload  (ioctl_upload),
    .ioctl_index   (ioctl_index),
    .ioctl_addr    (ioctl_addr),
    .ioctl_wr      (ioctl_wr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_din     (ioctl_din),
    .nvram_a       (nvram_a),
    .nvram_d       (nvram_d),
    .nvram_we      (nvram_we),
    .nvram_q       (nvram_q),
    .core_wr       (core_wr),
    .busy          (busy),
    .dirty         (dirty)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Synchronous NVRAM: read data one cycle after the address.
  always @(posedge clk_sys) begin
    if (nvram_we) mem[nvram_a] <= nvram_d;
    nvram_q <= mem[nvram_a];
  end

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops expectations when the DUT writes or completes a fetch.
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      busy_prev = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (nvram_we) begin
        if (wq.size() == 0) begin
          check("unexpected_we", 32'(nvram_we), 32'd0);
        end else begin
          wr_exp_t e;
          e = wq.pop_front();
          check("we_addr", 32'(nvram_a), 32'(e.a));
          check("we_data", 32'(nvram_d), 32'(e.d));
          check("we_cycle", cyc, e.cyc);
        end
      end
      if (busy) begin
        busy_cnt++;
      end else if (busy_prev) begin
        if (rq.size() == 0) begin
          check("unexpected_fetch", 32'(busy_prev), 32'd0);
        end else begin
          rd_exp_t r;
          r = rq.pop_front();
          check("din", 32'(ioctl_din), 32'(r.d));
          check("busy_len", busy_cnt, r.busy_len);
          check("din_cycle", cyc, r.cyc);
        end
        busy_cnt = 0;
      end
      busy_prev = busy;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk_sys);
  endtask

  function automatic logic [7:0] exp_rd(input logic [24:0] a);
    logic [8:0] ai;
    ai = a[8:0];
    return (a < 25'(NV)) ? ref_mem[ai] : 8'hFF;
  endfunction

  // One download byte; ioctl_wr held two cycles so a second pulse would show.
  task automatic dl_write(input logic [24:0] a, input logic [7:0] d);
    wr_exp_t e;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (a < 25'(NV)) begin
      e.a = a[8:0];
      e.d = d;
      e.cyc = cyc + 1;
      wq.push_back(e);
      ref_mem[a[8:0]] = d;
    end
    step(2);
    ioctl_wr = 1'b0;
    step(1);
  endtask

  task automatic push_rd(input logic [7:0] d, input int blen, input int at);
    rd_exp_t r;
    r.d = d;
    r.busy_len = blen;
    r.cyc = at;
    rq.push_back(r);
  endtask

  task automatic ul_begin(input logic [24:0] a);
    ioctl_addr   = a;
    ioctl_upload = 1'b1;
    push_rd(exp_rd(a), 2, cyc + 3);
    step(3);
  endtask

  task automatic ul_addr(input logic [24:0] a);
    ioctl_addr = a;
    push_rd(exp_rd(a), 2, cyc + 3);
    step(3);
  endtask

  task automatic pulse_core_wr;
    core_wr = 1'b1;
    step(1);
    core_wr = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    checks = 0;
    errors = 0;
    cyc    = 0;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_upload   = 1'b0;
    ioctl_index    = 8'hFF;
    ioctl_addr     = 25'd0;
    ioctl_wr       = 1'b0;
    ioctl_dout     = 8'h00;
    core_wr        = 1'b0;
    for (int i = 0; i < NV; i++) begin
      mem[i]     = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    mem[9'h1FF]     = 8'h3C;
    ref_mem[9'h1FF] = 8'h3C;

    // Reset state
    step(2);
    check("rst_din", 32'(ioctl_din), 32'h00);
    check("rst_a", 32'(nvram_a), 32'h0);
    check("rst_d", 32'(nvram_d), 32'h00);
    check("rst_we", 32'(nvram_we), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_dirty", 32'(dirty), 32'h0);
    reset_n = 1'b1;
    step(2);

    // Download: in-range writes and two out-of-range ones (one aliases 0x005)
    ioctl_download = 1'b1;
    step(2);
    dl_write(25'h005, 8'hA5);
    dl_write(25'h0AB, 8'h3E);
    dl_write(25'h200, 8'h77);
    dl_write(25'h1000005, 8'h99);
    ioctl_download = 1'b0;
    step(2);

    // Upload: top byte, freshly written bytes, out-of-range reads
    ul_begin(25'h1FF);
    ul_addr(25'h005);
    ul_addr(25'h200);
    check("oor_no_read", 32'(nvram_a), 32'h005);
    ul_addr(25'h0AB);
    ul_addr(25'h1000000);
    ul_addr(25'h000);

    // Address change during the fetch: only the second byte may appear
    k = cyc;
    ioctl_addr = 25'h010;
    step(2);
    ioctl_addr = 25'h011;
    push_rd(ref_mem[9'h011], 4, k + 5);
    step(4);
    ioctl_upload = 1'b0;
    step(2);

    // Unselected index: no writes, no fetch, ioctl_din held
    ioctl_index = 8'h01;
    ioctl_download = 1'b1;
    step(2);
    ioctl_addr = 25'h007;
    ioctl_dout = 8'hEE;
    ioctl_wr = 1'b1;
    step(2);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    step(1);
    ioctl_upload = 1'b1;
    step(4);
    check("unsel_busy", 32'(busy), 32'h0);
    check("unsel_din_held", 32'(ioctl_din), 32'(ref_mem[9'h011]));
    ioctl_upload = 1'b0;
    ioctl_index = 8'hFF;
    step(2);

    // Download and upload together: download wins, upload stays ignored
    ioctl_download = 1'b1;
    ioctl_upload   = 1'b1;
    step(2);
    dl_write(25'h020, 8'hC3);
    ioctl_download = 1'b0;
    step(4);
    check("both_no_upload", 32'(busy), 32'h0);
    ioctl_upload = 1'b0;
    step(2);

    // Dirty tracking: set, clear by a full save, clear collision
    pulse_core_wr();
    check("dirty_set", 32'(dirty), 32'(DT));
    ul_begin(25'h000);
    for (int a = 1; a < NV; a++) ul_addr(25'(a));
    ioctl_upload = 1'b0;
    step(2);
    check("dirty_clr_save", 32'(dirty), 32'h0);
    pulse_core_wr();
    check("dirty_set2", 32'(dirty), 32'(DT));
    ul_begin(25'h1FF);
    ioctl_upload = 1'b0;
    pulse_core_wr();
    check("dirty_collide", 32'(dirty), 32'(DT));
    step(1);
    ioctl_download = 1'b1;
    step(2);
    ioctl_download = 1'b0;
    step(2);
    check("dirty_clr_load", 32'(dirty), 32'h0);

    // Asynchronous reset in the middle of a download write
    ioctl_download = 1'b1;
    step(2);
    ioctl_addr = 25'h009;
    ioctl_dout = 8'h66;
    ioctl_wr   = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("arst_din", 32'(ioctl_din), 32'h00);
    check("arst_a", 32'(nvram_a), 32'h0);
    check("arst_d", 32'(nvram_d), 32'h00);
    check("arst_we", 32'(nvram_we), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_dirty", 32'(dirty), 32'h0);
    step(1);
    reset_n = 1'b1;
    step(1);
    ioctl_wr = 1'b0;
    step(1);
    ioctl_wr = 1'b1;
    step(2);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    step(2);
    ioctl_download = 1'b1;
    step(2);
    dl_write(25'h009, 8'h66);
    ioctl_download = 1'b0;
    step(2);

    // Drain: every expected event must have been seen
    for (int i = 0; i < 20 && (wq.size() != 0 || rq.size() != 0); i++) step(1);
    check("wr_queue_drained", wq.size(), 0);
    check("rd_queue_drained", rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
